imem_fetch_queue: RTL

Instruction-fetch front end between the instruction memory bus and the core's IF port. Turns the core's next-PC stream into pipelined, in-order memory requests and holds the returned parcels in a DEPTH-entry queue. Presents them to the core with PC and fault flags, and discards in-flight responses on a flush. Sits directly upstream of the core's `if_*` inputs.

---
 rtl/imem_fetch_queue.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_queue.sv
// imem_fetch_queue: instruction-fetch front end.
// Turns the core's next-PC stream into pipelined, in-order instruction memory
// requests. Returned parcels are held in a DEPTH-entry queue and presented to
// the core together with their PC and fault flags. A flush discards every
// queued parcel and drops any responses that are still in flight.
//
// Optional feature: define IMEM_FETCH_BYPASS_EN to present a response that
// lands in the head slot combinationally, in the same cycle as its ack.
// Without it, every parcel is presented from the slot registers one cycle
// after its ack.

module imem_fetch_queue #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 4
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [XLEN-1:0]           if_nxt_pc,
  output logic                      if_stall_nxt_pc,
  input  logic                      if_stall,
  input  logic                      if_flush,
  output logic [PARCEL_SIZE-1:0]    if_parcel,
  output logic [XLEN-1:0]           if_parcel_pc,
  output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
  output logic                      if_parcel_misaligned,
  output logic                      if_parcel_bus_err,

  output logic                      imem_req,
  output logic [XLEN-1:0]           imem_adr,
  input  logic                      imem_ack,
  input  logic [XLEN-1:0]           imem_q,
  input  logic                      imem_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int VW = PARCEL_SIZE / 16;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state;

  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] rd_ptr;

  logic [CW-1:0] used_cnt;
  logic [CW-1:0] pend_cnt;
  logic [CW-1:0] discard_cnt;

  logic [XLEN-1:0]        slot_pc   [DEPTH];
  logic [PARCEL_SIZE-1:0] slot_data [DEPTH];
  logic [DEPTH-1:0]       slot_mis;
  logic [DEPTH-1:0]       slot_err;
  logic [DEPTH-1:0]       slot_filled;

  logic          head_filled;
  logic          ack_fill;
  logic          bypass_hit;
  logic          present;
  logic          pop;
  logic          fill_write;
  logic          flushing;
  logic [CW-1:0] used_next;
  logic [CW-1:0] pend_next;
  logic [CW-1:0] flush_discard;

  // Head status, accepted-ack qualification, pop and request strobes.
  always_comb begin
    head_filled = slot_filled[rd_ptr];
    ack_fill    = imem_ack && (discard_cnt == '0) && (pend_cnt != '0);
    bypass_hit  = 1'b0;
`ifdef IMEM_FETCH_BYPASS_EN
    bypass_hit  = ack_fill && (fill_ptr == rd_ptr) && (used_cnt != '0) && !head_filled;
`endif
    present     = (used_cnt != '0) && (head_filled || bypass_hit) && !if_flush;
    pop         = present && !if_stall;
    flushing    = (state == ST_RUN) && if_flush;
    imem_req    = (state == ST_RUN) && !if_flush && ((used_cnt < DEPTH_C) || pop);
    imem_adr    = if_nxt_pc;
    if_stall_nxt_pc = !imem_req;
    fill_write  = ack_fill && !flushing && !(bypass_hit && pop);
    used_next   = used_cnt + CW'(imem_req) - CW'(pop);
    pend_next   = pend_cnt + CW'(imem_req) - CW'(ack_fill);
    flush_discard = pend_cnt - CW'(ack_fill);
  end

  // Head parcel presentation; every field reads zero when nothing is presented.
  always_comb begin
    if_parcel            = '0;
    if_parcel_pc         = '0;
    if_parcel_valid      = '0;
    if_parcel_misaligned = 1'b0;
    if_parcel_bus_err    = 1'b0;
    if (present) begin
      if_parcel_valid      = {VW{1'b1}};
      if_parcel_pc         = slot_pc[rd_ptr];
      if_parcel_misaligned = slot_mis[rd_ptr];
      if (bypass_hit) begin
        if_parcel         = imem_q;
        if_parcel_bus_err = imem_err;
      end else begin
        if_parcel         = slot_data[rd_ptr];
        if_parcel_bus_err = slot_err[rd_ptr];
      end
    end
  end

  // Control FSM with slot pointers and the used/pending/discard counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      used_cnt    <= '0;
      pend_cnt    <= '0;
      discard_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (if_flush) begin
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            used_cnt    <= '0;
            pend_cnt    <= '0;
            discard_cnt <= flush_discard;
            state       <= (flush_discard != '0) ? ST_DRAIN : ST_RUN;
          end else begin
            alloc_ptr <= alloc_ptr + PW'(imem_req);
            fill_ptr  <= fill_ptr + PW'(ack_fill);
            rd_ptr    <= rd_ptr + PW'(pop);
            used_cnt  <= used_next;
            pend_cnt  <= pend_next;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            discard_cnt <= discard_cnt - CW'(1);
            if (discard_cnt == CW'(1)) begin
              state <= ST_RUN;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Slot storage: allocation writes pc/misaligned, accepted acks write data/err.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc[i]   <= '0;
        slot_data[i] <= '0;
      end
      slot_mis    <= '0;
      slot_err    <= '0;
      slot_filled <= '0;
    end else begin
      if (fill_write) begin
        slot_data[fill_ptr]   <= imem_q;
        slot_err[fill_ptr]    <= imem_err;
        slot_filled[fill_ptr] <= 1'b1;
      end
      if (imem_req) begin
        slot_pc[alloc_ptr]     <= if_nxt_pc;
        slot_mis[alloc_ptr]    <= (if_nxt_pc[1:0] != 2'b00);
        slot_filled[alloc_ptr] <= 1'b0;
      end
    end
  end

endmodule
